ddr_wr_pack_fifo: RTL and testbench
===================================

Name: ddr_wr_pack_fifo

Overview:
- Single-clock, parametrised write-side buffer for the DDR AXI write path.
- Packs PACK narrow input samples into one wide AXI beat and stores beats in an internal FIFO.
- Flags when a full burst is available to the AXI master.
- Adds partial-word flush with lane mask, drop accounting and simultaneous push/pop at full, so the write-path front end no longer needs a vendor FIFO.

Parameters:
IN_W, 32, input sample width in bits
PACK, 4, samples per output beat; power of 2, >=2
DEPTH, 256, FIFO depth in output beats; power of 2
CNT_W, $clog2(DEPTH)+1, width of the occupancy count

Ports:
WrClk  in  1  clock; all logic on rising edge
Rst  in  1  synchronous, active-high reset
En  in  1  input enable; samples accepted only when high
DataIn  in  IN_W  input sample
DataInValid  in  1  DataIn qualifier
Flush  in  1  single-cycle pulse: push any partial beat
FlushDone  out  1  single-cycle pulse: flush complete
RdEn  in  1  read request from AXI write master
DataOut  out  IN_W*PACK  packed beat
DataOutMask  out  PACK  per-lane valid mask of DataOut
DataOutValid  out  1  DataOut/DataOutMask qualifier
Empty  out  1  FIFO holds no beats
Full  out  1  FIFO holds DEPTH beats
Count  out  CNT_W  beats stored
BurstThread  in  8  beats per AXI burst
OverBurstThread  out  1  Count >= BurstThread
DropCnt  out  16  beats lost to overflow; saturating

Behaviour:
- Reset: all outputs 0 except Empty=1. lane_cnt=0; pointers=0; FSM=RUN. Reset mid-operation discards all stored and partial data.
- Accept: sample accepted when En && DataInValid. Sample k of a beat goes to bits [k*IN_W +: IN_W]. lane_cnt increments mod PACK. En low freezes the partial beat; it is not discarded.
- Push:
  - The accept that fills lane PACK-1 assembles the beat combinationally (pack register + current DataIn) and pushes it at the same edge with mask all-ones.
  - Empty deasserts and Count increments after that edge.
- Overflow:
  - Push allowed when !Full, or when Full && pop_fire in the same cycle (Count unchanged).
  - Otherwise the beat is dropped, DropCnt increments (saturating at 16'hFFFF) and lane_cnt returns to 0.
  - Input is never back-pressured.
- Pop: pop_fire = RdEn && !Empty.
  - DataOut/DataOutMask are registered from memory; DataOutValid=1 exactly one cycle after pop_fire.
  - RdEn on Empty is ignored: no pointer move, DataOutValid=0.
  - DataOut holds its last value when not valid.
- Count: +1 on push only, -1 on pop only, unchanged on both or neither. Full = (Count==DEPTH). Empty = (Count==0). Both registered, consistent with Count.
- OverBurstThread: registered as (BurstThread!=0) && (Count >= BurstThread), one cycle after Count changes. BurstThread=0 forces 0. BurstThread>DEPTH means it never asserts.
- Pointers: $clog2(DEPTH) bits, natural wrap.
- Flush FSM:
  - RUN: on Flush go to FLUSH.
    - A valid sample accepted in the same cycle is absorbed first.
    - If that sample completes the beat, it pushes normally and no partial remains.
  - FLUSH, one cycle:
    - If lane_cnt>0, push the partial beat: unused lanes zero, mask bit k = (k < lane_cnt). Overflow rules apply.
    - lane_cnt=0. FlushDone=1. Return to RUN.
    - Samples arriving in FLUSH start the next beat after the partial is pushed (they occupy lane 0).
  - Flush while in FLUSH is ignored.
  - Flush with lane_cnt==0 pushes nothing; FlushDone still pulses one cycle after Flush.

Decomposition:
- Package ddr_fifo_pkg holds:
  - defaults for IN_W, PACK, DEPTH;
  - the FSM state enum {RUN, FLUSH};
  - localparams OUT_W = IN_W*PACK, PTR_W = $clog2(DEPTH), LANE_W = $clog2(PACK).
- One sub-module, ddr_sync_fifo_core: simple dual-port RAM of width OUT_W+PACK, wr/rd pointers, Count/Full/Empty, registered read data and valid.
- The top level holds the packer, flush FSM, drop counter and threshold flag.

Test Plan:
- Pack and read: defaults; feed 8 samples 0x11111111..0x88888888, then RdEn for 2 cycles -> first DataOut=0x44444444_33333333_22222222_11111111, mask 4'hF; Count sequence 0,1,2,1,0; DataOutValid one cycle after each pop.
- Burst flag: BurstThread=4; push 4 beats -> OverBurstThread rises one cycle after Count=4 and falls one cycle after the first pop. BurstThread=0 -> flag stays 0.
- Overflow:
  - DEPTH=4; push 6 beats without reads -> Full=1, DropCnt=2, Count=4; reads return beats 0..3 only.
  - Push coincident with pop at Full -> Count stays 4, DropCnt unchanged.
- Flush partial:
  - 3 samples then Flush -> beat with lane3=0, DataOutMask=4'b0111; FlushDone one cycle after Flush.
  - Flush with lane_cnt=0 -> no push, FlushDone still pulses.
- Edge events: Flush in the same cycle as the 4th sample -> one full beat, no extra partial. RdEn while Empty -> DataOutValid=0, Count=0. En low mid-beat for 10 cycles, then 2 more samples -> beat intact.
- Reset mid-stream: 2 beats stored plus 2 partial samples, Rst 1 cycle -> Empty=1, Count=0, DropCnt=0; the next 4 samples form a clean beat.

Source files
------------

// File: rtl/ddr_fifo_pkg.sv
// ddr_fifo_pkg: shared defaults, flush FSM states and derived widths for the DDR write-side pack FIFO
package ddr_fifo_pkg;
  localparam int IN_W_DEF  = 32;
  localparam int PACK_DEF  = 4;
  localparam int DEPTH_DEF = 256;
  localparam int OUT_W     = IN_W_DEF * PACK_DEF;
  localparam int PTR_W     = $clog2(DEPTH_DEF);
  localparam int LANE_W    = $clog2(PACK_DEF);
  typedef enum logic {RUN, FLUSH} state_e;
endpackage

// File: rtl/ddr_wr_pack_fifo_if.sv
// ddr_wr_pack_fifo_if: sample input, flush, read and status signals of the write-side pack FIFO (slave = FIFO, master = user)
interface ddr_wr_pack_fifo_if import ddr_fifo_pkg::*; #(
  parameter int IN_W  = IN_W_DEF,
  parameter int PACK  = PACK_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = $clog2(DEPTH) + 1
);
  logic                 En;
  logic [IN_W-1:0]      DataIn;
  logic                 DataInValid;
  logic                 Flush;
  logic                 FlushDone;
  logic                 RdEn;
  logic [IN_W*PACK-1:0] DataOut;
  logic [PACK-1:0]      DataOutMask;
  logic                 DataOutValid;
  logic                 Empty;
  logic                 Full;
  logic [CNT_W-1:0]     Count;
  logic [7:0]           BurstThread;
  logic                 OverBurstThread;
  logic [15:0]          DropCnt;
  modport slave (
    input  En, DataIn, DataInValid, Flush, RdEn, BurstThread,
    output FlushDone, DataOut, DataOutMask, DataOutValid, Empty, Full, Count, OverBurstThread, DropCnt
  );
  modport master (
    output En, DataIn, DataInValid, Flush, RdEn, BurstThread,
    input  FlushDone, DataOut, DataOutMask, DataOutValid, Empty, Full, Count, OverBurstThread, DropCnt
  );
endinterface

// File: rtl/ddr_sync_fifo_core.sv
// ddr_sync_fifo_core: single-clock FIFO (ports clk, rst, push/wdata, rd_en -> rdata/rvalid, count/full/empty, pop_fire) with registered read data
module ddr_sync_fifo_core import ddr_fifo_pkg::*; #(
  parameter int W     = OUT_W + PACK_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             rd_en,
  output logic [W-1:0]     rdata,
  output logic             rvalid,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             pop_fire
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0] rdata_q, rdata_d;
  logic full_q, full_d, empty_q, empty_d, rvalid_q, rvalid_d, wr;
  // At full, a push is only taken when a pop frees the slot in the same cycle;
  // the read sees the old word since the write lands at the edge.
  always_comb begin
    pop_fire = rd_en && !empty_q;
    wr = push && (!full_q || pop_fire);
    wr_ptr_d = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_fire ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d = (wr && !pop_fire) ? count_q + CNT_W'(1) : (!wr && pop_fire) ? count_q - CNT_W'(1) : count_q;
    full_d = count_d == CNT_W'(DEPTH);
    empty_d = count_d == '0;
    rvalid_d = pop_fire;
    rdata_d = pop_fire ? mem[rd_ptr_q] : rdata_q;
  end
  always_ff @(posedge clk) if (wr) mem[wr_ptr_q] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      full_q <= full_d;
      empty_q <= empty_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
    end
  end
  assign rdata = rdata_q;
  assign rvalid = rvalid_q;
  assign count = count_q;
  assign full = full_q;
  assign empty = empty_q;
endmodule

// File: rtl/ddr_wr_pack_fifo.sv
// ddr_wr_pack_fifo: packs PACK samples into masked beats with partial flush, drop counting and burst flag (ports WrClk, Rst, bus slave)
module ddr_wr_pack_fifo import ddr_fifo_pkg::*; #(
  parameter int IN_W  = IN_W_DEF,
  parameter int PACK  = PACK_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic WrClk,
  input logic Rst,
  ddr_wr_pack_fifo_if.slave bus
);
  localparam int BEAT_W = IN_W * PACK;
  localparam int LB = $clog2(PACK);
  state_e state_q, state_d;
  logic [LB-1:0] lane_cnt_q, lane_cnt_d;
  logic [BEAT_W-1:0] pack_q, pack_d, beat;
  logic [PACK-1:0] mask;
  logic [15:0] drop_q, drop_d;
  logic done_q, done_d, obt_q, obt_d, acc, push_req, pop_fire;
  always_comb begin
    acc = bus.En && bus.DataInValid;
    state_d = state_q;
    lane_cnt_d = lane_cnt_q;
    pack_d = pack_q;
    beat = pack_q;
    mask = '1;
    push_req = 1'b0;
    if (state_q == FLUSH) begin
      // Partial beat: lanes at or above lane_cnt are zeroed and masked off.
      for (int k = 0; k < PACK; k++) begin
        mask[k] = LB'(k) < lane_cnt_q;
        if (!mask[k]) beat[k*IN_W +: IN_W] = '0;
      end
      push_req = lane_cnt_q != '0;
      state_d = RUN;
      lane_cnt_d = acc ? LB'(1) : '0;
      if (acc) pack_d[IN_W-1:0] = bus.DataIn;
    end else begin
      state_d = bus.Flush ? FLUSH : RUN;
      if (acc) begin
        pack_d[lane_cnt_q*IN_W +: IN_W] = bus.DataIn;
        beat = pack_d;
        push_req = lane_cnt_q == LB'(PACK - 1);
        lane_cnt_d = lane_cnt_q + LB'(1);
      end
    end
    drop_d = (push_req && bus.Full && !pop_fire && drop_q != '1) ? drop_q + 16'd1 : drop_q;
    done_d = state_q == RUN && bus.Flush;
    obt_d = bus.BurstThread != '0 && 32'(bus.Count) >= 32'(bus.BurstThread);
  end
  always_ff @(posedge WrClk) begin
    if (Rst) begin
      state_q <= RUN;
      lane_cnt_q <= '0;
      pack_q <= '0;
      drop_q <= '0;
      done_q <= 1'b0;
      obt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_cnt_q <= lane_cnt_d;
      pack_q <= pack_d;
      drop_q <= drop_d;
      done_q <= done_d;
      obt_q <= obt_d;
    end
  end
  ddr_sync_fifo_core #(.W(BEAT_W + PACK), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_core (
    .clk(WrClk),
    .rst(Rst),
    .push(push_req),
    .wdata({mask, beat}),
    .rd_en(bus.RdEn),
    .rdata({bus.DataOutMask, bus.DataOut}),
    .rvalid(bus.DataOutValid),
    .count(bus.Count),
    .full(bus.Full),
    .empty(bus.Empty),
    .pop_fire(pop_fire)
  );
  assign bus.FlushDone = done_q;
  assign bus.DropCnt = drop_q;
  assign bus.OverBurstThread = obt_q;
endmodule

// File: tb/tb_ddr_wr_pack_fifo.sv
// tb_ddr_wr_pack_fifo: directed bench with packer/FIFO model and scoreboard for ddr_wr_pack_fifo
module tb_ddr_wr_pack_fifo;
  localparam int D = 4;
  logic WrClk = 1'b0;
  logic Rst = 1'b1;
  always #5 WrClk = ~WrClk;
  ddr_wr_pack_fifo_if #(.IN_W(32), .PACK(4), .DEPTH(D)) b ();
  ddr_wr_pack_fifo #(.IN_W(32), .PACK(4), .DEPTH(D)) dut (.WrClk(WrClk), .Rst(Rst), .bus(b));
  int checks = 0;
  int failures = 0;
  logic [31:0] lanes [4];
  int lc = 0, mc = 0, md = 0, bt = 0;
  bit infl = 0;
  logic [131:0] sb [$];
  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(bit v, logic [31:0] d, bit fl, bit rd, bit en);
    logic [131:0] beat, exp;
    bit push, pop, ok, dn;
    int pre;
    pre = mc;
    pop = rd && mc > 0;
    push = 0;
    beat = '0;
    exp = '0;
    dn = fl && !infl;
    if (infl) begin
      if (lc > 0) begin
        for (int k = 0; k < lc; k++) begin
          beat[k*32 +: 32] = lanes[k];
          beat[128+k] = 1'b1;
        end
        push = 1;
      end
      lc = 0;
      infl = 0;
      if (v && en) begin lanes[0] = d; lc = 1; end
    end else begin
      if (v && en) begin
        lanes[lc] = d;
        lc++;
        if (lc == 4) begin
          beat = {4'hF, lanes[3], lanes[2], lanes[1], lanes[0]};
          push = 1;
          lc = 0;
        end
      end
      infl = fl;
    end
    ok = push && (mc < D || pop);
    if (push && !ok && md < 65535) md++;
    if (pop) exp = sb.pop_front();
    if (ok) sb.push_back(beat);
    mc = mc + int'(ok) - int'(pop);
    b.En = en; b.DataInValid = v; b.DataIn = d; b.Flush = fl; b.RdEn = rd; b.BurstThread = 8'(bt);
    @(posedge WrClk);
    #1;
    chk("valid", b.DataOutValid, pop);
    if (pop) begin
      chk("data", b.DataOut, exp[127:0]);
      chk("mask", b.DataOutMask, exp[131:128]);
    end
    chk("count", b.Count, mc);
    chk("empty", b.Empty, mc == 0);
    chk("full", b.Full, mc == D);
    chk("drop", b.DropCnt, md);
    chk("flushdone", b.FlushDone, dn);
    chk("overburst", b.OverBurstThread, bt != 0 && pre >= bt);
    b.En = 0; b.DataInValid = 0; b.Flush = 0; b.RdEn = 0;
  endtask
  task automatic smp(logic [31:0] d);
    drive(1, d, 0, 0, 1);
  endtask
  task automatic rd();
    drive(0, 0, 0, 1, 1);
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 1);
  endtask
  task automatic do_reset();
    Rst = 1;
    @(posedge WrClk);
    #1;
    Rst = 0;
    lc = 0; mc = 0; md = 0; infl = 0;
    sb.delete();
    chk("rst_empty", b.Empty, 1);
    chk("rst_full", b.Full, 0);
    chk("rst_count", b.Count, 0);
    chk("rst_valid", b.DataOutValid, 0);
    chk("rst_drop", b.DropCnt, 0);
    chk("rst_done", b.FlushDone, 0);
    chk("rst_obt", b.OverBurstThread, 0);
  endtask
  initial begin
    b.En = 0; b.DataIn = '0; b.DataInValid = 0; b.Flush = 0; b.RdEn = 0; b.BurstThread = '0;
    do_reset();
    for (int i = 1; i <= 8; i++) smp({8{4'(i)}});
    chk("two_beats", b.Count, 2);
    rd();
    chk("first_beat", b.DataOut, 128'h44444444_33333333_22222222_11111111);
    chk("first_mask", b.DataOutMask, 4'hF);
    rd();
    idle();
    bt = 4;
    for (int i = 0; i < 16; i++) smp(32'h1000 + i);
    chk("obt_lag", b.OverBurstThread, 0);
    idle();
    chk("obt_rise", b.OverBurstThread, 1);
    rd();
    idle();
    chk("obt_fall", b.OverBurstThread, 0);
    for (int i = 0; i < 3; i++) rd();
    bt = 0;
    for (int i = 0; i < 16; i++) smp(32'h2000 + i);
    idle();
    chk("obt_zero", b.OverBurstThread, 0);
    for (int i = 0; i < 8; i++) smp(32'h3000 + i);
    chk("ovf_drop", b.DropCnt, 2);
    chk("ovf_count", b.Count, 4);
    chk("ovf_full", b.Full, 1);
    for (int i = 0; i < 3; i++) smp(32'h4000 + i);
    drive(1, 32'h4003, 0, 1, 1);
    chk("pushpop_count", b.Count, 4);
    chk("pushpop_drop", b.DropCnt, 2);
    for (int i = 0; i < 4; i++) rd();
    rd();
    chk("rd_empty_count", b.Count, 0);
    for (int i = 0; i < 3; i++) smp(32'h5000 + i);
    drive(0, 0, 1, 0, 1);
    chk("flush_done", b.FlushDone, 1);
    idle();
    rd();
    chk("partial_mask", b.DataOutMask, 4'b0111);
    chk("partial_data", b.DataOut, 128'h00000000_00005002_00005001_00005000);
    drive(0, 0, 1, 0, 1);
    idle();
    chk("empty_flush_count", b.Count, 0);
    for (int i = 0; i < 3; i++) smp(32'h6000 + i);
    drive(1, 32'h6003, 1, 0, 1);
    idle();
    idle();
    chk("flush4_count", b.Count, 1);
    rd();
    smp(32'h7000); smp(32'h7001);
    drive(0, 0, 1, 0, 1);
    drive(1, 32'h7002, 1, 0, 1);
    for (int i = 3; i < 6; i++) smp(32'h7000 + i);
    rd(); rd();
    smp(32'h8000); smp(32'h8001);
    for (int i = 0; i < 10; i++) drive(1, 32'hDEAD0000 + i, 0, 0, 0);
    smp(32'h8002); smp(32'h8003);
    rd();
    chk("enlow_beat", b.DataOut, 128'h00008003_00008002_00008001_00008000);
    for (int i = 0; i < 10; i++) smp(32'h9000 + i);
    do_reset();
    for (int i = 0; i < 4; i++) smp(32'hA000 + i);
    rd();
    chk("post_rst_beat", b.DataOut, 128'h0000A003_0000A002_0000A001_0000A000);
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
